// File: rtl/cmp_serial_sched.sv
// Time-shares one external 1-bit comparator cell between N requesters.
// The winning operand pair is walked MSB-first, and the walk stops at the first unequal bit.
module cmp_serial_sched #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  a_flat,
  input  logic [N*W-1:0]  b_flat,
  output logic [N-1:0]    gnt,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic            rsp_eq,
  output logic            rsp_gt,
  output logic            rsp_lt,
  output logic            rsp_err,
  output logic            busy,
  output logic            cmp_a,
  output logic            cmp_b,
  input  logic            cmp_eq,
  input  logic            cmp_gt,
  input  logic            cmp_lt
);

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_next;
  logic [ID_W-1:0]  rr_ptr, sel, cand;
  logic             sel_found;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     op_a, op_b;
  logic [W-1:0]     a_arr [N];
  logic [W-1:0]     b_arr [N];
  logic [2:0]       cmp_vec;
  logic             cmp_onehot;
  logic             scan_stop;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign a_arr[g] = a_flat[g*W +: W];
    assign b_arr[g] = b_flat[g*W +: W];
  end

  // Round-robin search: the first requester at or after rr_ptr, wrapping.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N);
      if (!sel_found && req[cand]) begin
        sel       = cand;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    cmp_vec    = {cmp_eq, cmp_gt, cmp_lt};
    cmp_onehot = (cmp_vec == 3'b100) || (cmp_vec == 3'b010) || (cmp_vec == 3'b001);
    scan_stop  = !cmp_onehot || cmp_gt || cmp_lt || (idx == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (sel_found) state_next = SCAN;
      SCAN:    if (scan_stop) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      idx     <= IDX_W'(W - 1);
      op_a    <= '0;
      op_b    <= '0;
      gnt     <= '0;
      rsp_id  <= '0;
      rsp_eq  <= 1'b0;
      rsp_gt  <= 1'b0;
      rsp_lt  <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      gnt <= '0;
      unique case (state)
        IDLE: begin
          if (sel_found) begin
            op_a     <= a_arr[sel];
            op_b     <= b_arr[sel];
            rsp_id   <= sel;
            idx      <= IDX_W'(W - 1);
            gnt[sel] <= 1'b1;
          end
        end
        SCAN: begin
          // A malformed comparator output ends the job with only the error flag set.
          if (!cmp_onehot) begin
            rsp_err <= 1'b1;
            rsp_eq  <= 1'b0;
            rsp_gt  <= 1'b0;
            rsp_lt  <= 1'b0;
          end else if (cmp_gt || cmp_lt) begin
            rsp_err <= 1'b0;
            rsp_eq  <= 1'b0;
            rsp_gt  <= cmp_gt;
            rsp_lt  <= cmp_lt;
          end else if (idx == '0) begin
            rsp_err <= 1'b0;
            rsp_eq  <= 1'b1;
            rsp_gt  <= 1'b0;
            rsp_lt  <= 1'b0;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        DONE: begin
          if (rsp_ready) rr_ptr <= ID_W'((int'(rsp_id) + 1) % N);
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign cmp_a     = (state == SCAN) ? op_a[idx] : 1'b0;
  assign cmp_b     = (state == SCAN) ? op_b[idx] : 1'b0;

endmodule
